// File: rtl/shader_pkg.sv
// Shared definitions for the triangle feeder and its shader-side neighbours.
//   FACE_WORDS     : number of 16-bit words in one face record (3 vertices x 3 coords)
//   vertex_t       : one vertex, 16-bit x/y/z
//   feeder_state_t : control states of the face-list feeder
package shader_pkg;

  localparam int FACE_WORDS = 9;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } vertex_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    NEXT   = 3'd4
  } feeder_state_t;

endpackage

// File: rtl/triangle_feeder.sv
// Triangle feeder: walks a list of face records in memory, loads the three
// vertices of each face, launches the shader and waits for it to finish
// before moving on to the next face.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   go         : one-cycle list request (accepted only in IDLE)
//   base_addr  : word address of the first face record (sampled on accepted go)
//   num_faces  : number of faces in the list (sampled on accepted go)
//   mem_rd     : read strobe to synchronous memory
//   mem_addr   : read word address
//   mem_rdata  : read data, valid one cycle after mem_rd
//   v1x..v3z   : vertex coordinates presented to the shader
//   start      : shader launch strobe, high for START_CYC cycles per face
//   done       : shader completion (level or pulse, sampled only in WAIT)
//   busy       : high while a list is being processed
//   list_done  : one-cycle pulse when the list is finished
module triangle_feeder
  import shader_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int START_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        num_faces,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       v1x,
  output logic [15:0]       v1y,
  output logic [15:0]       v1z,
  output logic [15:0]       v2x,
  output logic [15:0]       v2y,
  output logic [15:0]       v2z,
  output logic [15:0]       v3x,
  output logic [15:0]       v3y,
  output logic [15:0]       v3z,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic              list_done
);

  localparam int LC_W = (START_CYC > 1) ? $clog2(START_CYC) : 1;

  feeder_state_t     state_q, state_d;
  logic [3:0]        fidx_q, fidx_d;      // cycle index inside FETCH, 0..9
  logic [LC_W-1:0]   lcnt_q, lcnt_d;      // cycle index inside LAUNCH
  logic [ADDR_W-1:0] ptr_q, ptr_d;        // address of current face record
  logic [7:0]        cnt_q, cnt_d;        // faces remaining, including current
  logic              busy_q, busy_d;
  logic              list_done_q, list_done_d;
  vertex_t           vtx_q [3];
  vertex_t           vtx_d [3];

  // Reads are issued in FETCH cycles 0..8; cycle 9 only captures the last word.
  assign mem_rd    = (state_q == FETCH) && (fidx_q < 4'd9);
  assign mem_addr  = mem_rd ? (ptr_q + ADDR_W'(fidx_q)) : '0;
  assign start     = (state_q == LAUNCH);
  assign busy      = busy_q;
  assign list_done = list_done_q;

  assign v1x = vtx_q[0].x;
  assign v1y = vtx_q[0].y;
  assign v1z = vtx_q[0].z;
  assign v2x = vtx_q[1].x;
  assign v2y = vtx_q[1].y;
  assign v2z = vtx_q[1].z;
  assign v3x = vtx_q[2].x;
  assign v3y = vtx_q[2].y;
  assign v3z = vtx_q[2].z;

  always_comb begin
    state_d     = state_q;
    fidx_d      = fidx_q;
    lcnt_d      = lcnt_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    list_done_d = 1'b0;
    vtx_d       = vtx_q;

    unique case (state_q)
      IDLE: begin
        fidx_d = '0;
        lcnt_d = '0;
        if (go) begin
          if (num_faces != 8'd0) begin
            ptr_d   = base_addr;
            cnt_d   = num_faces;
            busy_d  = 1'b1;
            state_d = FETCH;
          end else begin
            list_done_d = 1'b1;
          end
        end
      end

      FETCH: begin
        fidx_d = fidx_q + 4'd1;
        // Data returned now belongs to the read issued in the previous cycle.
        unique case (fidx_q)
          4'd1:    vtx_d[0].x = mem_rdata;
          4'd2:    vtx_d[0].y = mem_rdata;
          4'd3:    vtx_d[0].z = mem_rdata;
          4'd4:    vtx_d[1].x = mem_rdata;
          4'd5:    vtx_d[1].y = mem_rdata;
          4'd6:    vtx_d[1].z = mem_rdata;
          4'd7:    vtx_d[2].x = mem_rdata;
          4'd8:    vtx_d[2].y = mem_rdata;
          4'd9:    vtx_d[2].z = mem_rdata;
          default: ;
        endcase
        if (fidx_q == 4'd9) begin
          fidx_d  = '0;
          lcnt_d  = '0;
          state_d = LAUNCH;
        end
      end

      LAUNCH: begin
        lcnt_d = lcnt_q + 1'b1;
        if (lcnt_q == LC_W'(START_CYC - 1)) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (done) begin
          state_d = NEXT;
          // Registered pulse lands in the NEXT cycle that retires the last face.
          if (cnt_q == 8'd1) begin
            list_done_d = 1'b1;
          end
        end
      end

      NEXT: begin
        ptr_d  = ptr_q + ADDR_W'(FACE_WORDS);
        cnt_d  = cnt_q - 8'd1;
        fidx_d = '0;
        if (cnt_q == 8'd1) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      fidx_q      <= '0;
      lcnt_q      <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      list_done_q <= 1'b0;
      vtx_q[0]    <= '0;
      vtx_q[1]    <= '0;
      vtx_q[2]    <= '0;
    end else begin
      state_q     <= state_d;
      fidx_q      <= fidx_d;
      lcnt_q      <= lcnt_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      list_done_q <= list_done_d;
      vtx_q[0]    <= vtx_d[0];
      vtx_q[1]    <= vtx_d[1];
      vtx_q[2]    <= vtx_d[2];
    end
  end

endmodule

// File: tb/tb_triangle_feeder.sv
// Bench for triangle_feeder: memory model, scoreboard of expected reads,
// vertex sets and start bursts, and a monitor that checks them as they appear.
module tb_triangle_feeder;

  localparam int ADDR_W    = 12;
  localparam int START_CYC = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              go;
  logic [ADDR_W-1:0] base_addr;
  logic [7:0]        num_faces;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic [15:0]       v1x, v1y, v1z, v2x, v2y, v2z, v3x, v3y, v3z;
  logic              start;
  logic              done;
  logic              busy;
  logic              list_done;

  triangle_feeder #(.ADDR_W(ADDR_W), .START_CYC(START_CYC)) dut (
    .clk(clk), .reset(reset), .go(go), .base_addr(base_addr), .num_faces(num_faces),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .v1x(v1x), .v1y(v1y), .v1z(v1z), .v2x(v2x), .v2y(v2y), .v2z(v2z),
    .v3x(v3x), .v3y(v3y), .v3z(v3z),
    .start(start), .done(done), .busy(busy), .list_done(list_done)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [4096];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  int errors = 0;
  int checks = 0;

  logic [ADDR_W-1:0] exp_addr [$];
  logic [143:0]      exp_vtx  [$];
  int exp_bursts = 0, got_bursts = 0;
  int exp_ld = 0, got_ld = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [143:0] vtx_out();
    return {v1x, v1y, v1z, v2x, v2y, v2z, v3x, v3y, v3z};
  endfunction

  // Monitor: compares every read, every start burst and every list_done pulse.
  initial begin
    logic start_prev = 1'b0;
    logic ld_prev    = 1'b0;
    int   burst_len  = 0;
    forever begin
      @(negedge clk);
      if (mem_rd) begin
        if (exp_addr.size() == 0) fail_now($sformatf("unexpected_read addr=%0h", mem_addr));
        else chk("rd_addr", 160'(mem_addr), 160'(exp_addr.pop_front()));
      end
      if (start && !start_prev) begin
        got_bursts++;
        burst_len = 1;
        if (exp_vtx.size() == 0) fail_now("unexpected_start");
        else chk("vertices", 160'(vtx_out()), 160'(exp_vtx.pop_front()));
      end else if (start) begin
        burst_len++;
      end
      if (!start && start_prev) chk("start_len", 160'(burst_len), 160'(START_CYC));
      if (list_done) begin
        got_ld++;
        chk("list_done_width", 160'(ld_prev), 160'(0));
      end
      start_prev = start;
      ld_prev    = list_done;
    end
  end

  task automatic rand_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
  endtask

  // Reference: face i occupies words base+9i .. base+9i+8, modulo 4096.
  task automatic go_list(input logic [ADDR_W-1:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      logic [143:0] vt = '0;
      for (int k = 0; k < 9; k++) begin
        logic [ADDR_W-1:0] a = b + ADDR_W'(9 * i + k);
        exp_addr.push_back(a);
        vt = {vt[127:0], mem[a]};
      end
      exp_vtx.push_back(vt);
    end
    exp_bursts += n;
    exp_ld++;
    @(negedge clk); #1;
    go = 1'b1; base_addr = b; num_faces = 8'(n);
    @(negedge clk);
    if (n == 0) begin
      chk("empty_list_done", 160'(list_done), 160'(1));
      chk("empty_busy", 160'(busy), 160'(0));
    end else begin
      chk("busy_after_go", 160'(busy), 160'(1));
    end
    #1 go = 1'b0;
  endtask

  task automatic wait_start_burst(output bit ok);
    int t = 0;
    ok = 1'b0;
    forever begin
      @(negedge clk);
      if (start) break;
      if (++t > 200) begin fail_now("timeout_start_rise"); return; end
    end
    t = 0;
    forever begin
      @(negedge clk);
      if (!start) break;
      if (++t > 50) begin fail_now("timeout_start_fall"); return; end
    end
    ok = 1'b1;
  endtask

  // Acts as the shader for n faces, with random delay and done width.
  task automatic serve_faces(input int n);
    bit ok;
    for (int f = 0; f < n; f++) begin
      wait_start_burst(ok);
      if (!ok) return;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      #1 done = 1'b1;
      @(negedge clk);
      chk("list_done_timing", 160'(list_done), 160'(f == n - 1));
      if ($urandom_range(0, 1) == 0) #1 done = 1'b0;
      @(negedge clk);
      chk("busy_after_face", 160'(busy), 160'(f != n - 1));
      #1 done = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    reset = 1'b1; go = 1'b0; done = 1'b0; base_addr = '0; num_faces = '0;
    mem_rdata = '0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", {mem_rd, mem_addr, start, busy, list_done, vtx_out()}, '0);
    #1 reset = 1'b0;

    // Single known face at address 0.
    mem[0] = 16'h30A9; mem[1] = 16'h1AB2; mem[2] = 16'h0100;
    mem[3] = 16'h315F; mem[4] = 16'h1B57; mem[5] = 16'h0100;
    mem[6] = 16'h27FC; mem[7] = 16'h1B5F; mem[8] = 16'h0100;
    go_list(12'h000, 1);
    serve_faces(1);
    chk("known_vertices", 160'(vtx_out()),
        160'(144'h30A9_1AB2_0100_315F_1B57_0100_27FC_1B5F_0100));

    // Empty list.
    repeat (3) @(negedge clk);
    go_list(12'h055, 0);
    repeat (5) @(negedge clk);

    // Three faces from 0x100.
    rand_mem();
    go_list(12'h100, 3);
    serve_faces(3);

    // done held through FETCH/LAUNCH and go pulsed while busy: all ignored.
    rand_mem();
    #1 done = 1'b1;
    go_list(12'h200, 1);
    for (int i = 0; i < 2; i++) begin
      #1 go = 1'b1; base_addr = 12'h700; num_faces = 8'd4;
      @(negedge clk); #1 go = 1'b0;
      @(negedge clk);
    end
    wait_start_burst(ok);
    #1 done = 1'b0;
    repeat (3) @(negedge clk);
    #1 go = 1'b1; base_addr = 12'h300;
    @(negedge clk); #1 go = 1'b0;
    repeat (3) @(negedge clk);
    chk("still_waiting_busy", 160'(busy), 160'(1));
    chk("still_waiting_ld", 160'(got_ld), 160'(exp_ld - 1));
    #1 done = 1'b1;
    @(negedge clk);
    chk("late_done_list_done", 160'(list_done), 160'(1));
    #1 done = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the 5th FETCH cycle, go ignored while reset is high.
    rand_mem();
    go_list(12'h040, 2);
    repeat (4) @(negedge clk);
    #1 reset = 1'b1;
    #1 chk("reset_mid_fetch", {mem_rd, mem_addr, start, busy, list_done, vtx_out()}, '0);
    exp_addr.delete();
    exp_vtx.delete();
    exp_bursts -= 2;
    exp_ld--;
    @(negedge clk); #1 go = 1'b1; base_addr = 12'h600; num_faces = 8'd3;
    @(negedge clk); #1 go = 1'b0;
    @(negedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("go_during_reset_busy", 160'(busy), 160'(0));
    go_list(12'h480, 1);
    serve_faces(1);

    // Address wrap at the top of the space.
    rand_mem();
    go_list(12'hFFC, 1);
    serve_faces(1);

    // Random lists.
    for (int r = 0; r < 4; r++) begin
      rand_mem();
      go_list(ADDR_W'($urandom_range(0, 4095)), $urandom_range(1, 4));
      serve_faces(exp_vtx.size());
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("addr_queue_drained", 160'(exp_addr.size()), 160'(0));
    chk("vtx_queue_drained", 160'(exp_vtx.size()), 160'(0));
    chk("start_burst_count", 160'(got_bursts), 160'(exp_bursts));
    chk("list_done_count", 160'(got_ld), 160'(exp_ld));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/triangle_feeder.md
TRIANGLE_FEEDER -- requirements
Module: triangle_feeder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word-address width of the face memory port.
REQ-002 SHALL have parameter START_CYC, default 2, number of cycles start is held high per face.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port go, input, 1, one-cycle request to process a face list.
REQ-006 SHALL have port base_addr, input, ADDR_W, word address of the first face record; sampled on accepted go.
REQ-007 SHALL have port num_faces, input, 8, face count; sampled on accepted go.
REQ-008 SHALL have port mem_rd, output, 1, read strobe to synchronous memory.
REQ-009 SHALL have port mem_addr, output, ADDR_W, read address.
REQ-010 SHALL have port mem_rdata, input, 16, read data, valid exactly 1 cycle after mem_rd.
REQ-011 SHALL have ports v1x, v1y, v1z, v2x, v2y, v2z, v3x, v3y, v3z, output, 16 each, vertex coordinates to the shader.
REQ-012 SHALL have port start, output, 1, shader launch strobe.
REQ-013 SHALL have port done, input, 1, shader completion; pulse of 1 or more cycles.
REQ-014 SHALL have port busy, output, 1, high from accepted go until list completion.
REQ-015 SHALL have port list_done, output, 1, one-cycle pulse when the whole list is finished.

Function
REQ-016 SHALL implement states IDLE, FETCH, LAUNCH, WAIT, NEXT.
REQ-017 SHALL store each face record as 9 consecutive 16-bit words, in order v1x,v1y,v1z,v2x,v2y,v2z,v3x,v3y,v3z.
REQ-018 SHALL leave IDLE on go: go to FETCH if num_faces is not 0; otherwise pulse list_done the next cycle and stay in IDLE.
REQ-019 SHALL ignore go whenever it is not in IDLE.
REQ-020 SHALL in FETCH assert mem_rd for 9 consecutive cycles with mem_addr = face pointer + 0..8, and capture mem_rdata into the matching vertex register one cycle after each read; FETCH lasts 10 cycles.
REQ-021 SHALL update vertex outputs only during FETCH; they are held stable through LAUNCH and WAIT.
REQ-022 SHALL in LAUNCH drive start high for exactly START_CYC cycles, then enter WAIT.
REQ-023 SHALL in WAIT sample done, ignoring done in every other state, and go to NEXT on the first cycle done is high.
REQ-024 SHALL in NEXT (1 cycle) advance the face pointer by 9 and decrement the remaining count; if the count reaches 0, pulse list_done, deassert busy, and return to IDLE, else go to FETCH.
REQ-025 SHALL wrap face pointer arithmetic modulo 2^ADDR_W.
REQ-026 SHALL wait for done without limit; there is no timeout.

Reset
REQ-027 SHALL on reset immediately, including mid-FETCH or mid-WAIT, go to IDLE with mem_rd, mem_addr, start, busy, list_done, all vertex outputs, the pointer, and the count at 0.
REQ-028 SHALL not accept go while reset is high.

Structure
REQ-029 SHALL take FACE_WORDS = 9, the vertex_t typedef (16-bit x/y/z struct), and the feeder state enum from shared package shader_pkg.
REQ-030 SHALL be a single module with no sub-module; the memory model belongs in the bench only.

Verification
REQ-031 SHALL verify: base_addr=0, num_faces=1, memory[0..8] = 30A9,1AB2,0100,315F,1B57,0100,27FC,1B5F,0100 -> vertex outputs equal those values, start high 2 cycles, then done pulse -> list_done one cycle later.
REQ-032 SHALL verify: num_faces=0 with go -> list_done the next cycle, no mem_rd, no start.
REQ-033 SHALL verify: num_faces=3, base_addr=0x100 -> reads at 0x100-0x108, 0x109-0x111, 0x112-0x11A, and exactly 3 start bursts.
REQ-034 SHALL verify: done held high during LAUNCH and go pulsed while busy -> both ignored, WAIT still waits for a later done, and the list is not restarted.
REQ-035 SHALL verify: reset asserted in the 5th FETCH cycle -> all outputs are 0 that same cycle, and a later go restarts from the new base_addr.
REQ-036 SHALL verify: base_addr=0xFFC, num_faces=1 (ADDR_W=12) -> addresses wrap 0xFFC..0xFFF, then 0x000..0x004.
